// File: rtl/crc_job_sequencer_pkg.sv
// Shared types and defaults for the CRC job sequencer.
// Contents: sequencer state encoding, latched job configuration payload, default widths.
package crc_job_sequencer_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned LEN_W_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CFG_POLY = 4'd1,
    ST_CFG_INIT = 4'd2,
    ST_RST      = 4'd3,
    ST_WAIT_RST = 4'd4,
    ST_FEED     = 4'd5,
    ST_DRAIN    = 4'd6,
    ST_DONE     = 4'd7,
    ST_ABORT    = 4'd8
  } seq_state_e;

  // Job configuration captured on an accepted start
  typedef struct packed {
    logic [DATA_W-1:0] poly;
    logic [DATA_W-1:0] init;
    logic [1:0]        poly_size;
    logic [1:0]        bus_size;
    logic [1:0]        rev_in;
    logic              rev_out;
  } crc_cfg_t;

endpackage

// File: rtl/crc_job_sequencer_timer.sv
// Watchdog timer for the sequencer wait states.
// Ports: clk, rst_n (sync, active-low), clr (zero the count, wins over en),
//        en (count up, saturating at TIMEOUT), count (current value),
//        tc_c (combinational: count has reached TIMEOUT).
module crc_job_sequencer_timer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc_c
);

  assign tc_c = (count == CNT_W'(TIMEOUT));

  // Saturating up-counter; clear has priority
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc_c) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/crc_job_sequencer.sv
// Runs one CRC job at a time through a crc_unit: programs poly/init, pulses
// reset_chain, streams job_len words from a valid/ready source, then waits
// for the result and returns it with done/err.
// Ports: clk, rst_n (sync, active-low); job_* request and configuration;
//        src_data/src_valid/src_ready stream; busy/done/err/result status;
//        crc_* outputs drive the crc_unit, crc_out/crc_buffer_full/
//        crc_read_wait/crc_reset_pending come back from it.
module crc_job_sequencer
  import crc_job_sequencer_pkg::*;
#(
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_start,
  input  logic              job_abort,
  input  logic [DATA_W-1:0] job_poly,
  input  logic [DATA_W-1:0] job_init,
  input  logic [1:0]        job_poly_size,
  input  logic [1:0]        job_bus_size,
  input  logic [1:0]        job_rev_in,
  input  logic              job_rev_out,
  input  logic [LEN_W-1:0]  job_len,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] crc_bus_wr,
  output logic [1:0]        crc_poly_size,
  output logic [1:0]        crc_bus_size,
  output logic [1:0]        crc_rev_in,
  output logic              crc_rev_out,
  output logic              crc_init_en,
  output logic              crc_poly_en,
  output logic              crc_idr_en,
  output logic              crc_buffer_write_en,
  output logic              crc_reset_chain,
  input  logic [DATA_W-1:0] crc_out,
  input  logic              crc_buffer_full,
  input  logic              crc_read_wait,
  input  logic              crc_reset_pending
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  seq_state_e       state, next_state;
  crc_cfg_t         cfg_q;
  logic [LEN_W-1:0] remaining;
  logic [TMR_W-1:0] tmr_count;
  logic             tmr_tc;
  logic             tmr_clr, tmr_en;
  logic             err_set, res_cap, rem_dec;
  logic             active;

  assign crc_poly_size = cfg_q.poly_size;
  assign crc_bus_size  = cfg_q.bus_size;
  assign crc_rev_in    = cfg_q.rev_in;
  assign crc_rev_out   = cfg_q.rev_out;
  assign crc_idr_en    = 1'b0;

  // Abort is only meaningful while a job is still in flight
  assign active = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ABORT);

  crc_job_sequencer_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (TMR_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .count (tmr_count),
    .tc_c  (tmr_tc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next state and crc_unit strobes
  always_comb begin
    next_state          = state;
    src_ready           = 1'b0;
    crc_bus_wr          = '0;
    crc_poly_en         = 1'b0;
    crc_init_en         = 1'b0;
    crc_reset_chain     = 1'b0;
    crc_buffer_write_en = 1'b0;
    tmr_clr             = 1'b0;
    tmr_en              = 1'b0;
    err_set             = 1'b0;
    res_cap             = 1'b0;
    rem_dec             = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (job_start) next_state = ST_CFG_POLY;
      end
      ST_CFG_POLY: begin
        crc_bus_wr  = cfg_q.poly;
        crc_poly_en = 1'b1;
        next_state  = ST_CFG_INIT;
      end
      ST_CFG_INIT: begin
        crc_bus_wr  = cfg_q.init;
        crc_init_en = 1'b1;
        next_state  = ST_RST;
      end
      ST_RST: begin
        crc_reset_chain = 1'b1;
        tmr_clr         = 1'b1;
        next_state      = ST_WAIT_RST;
      end
      ST_WAIT_RST: begin
        tmr_en = 1'b1;
        if (!crc_reset_pending) begin
          if (remaining == LEN_W'(0)) begin
            next_state = ST_DRAIN;
            tmr_clr    = 1'b1;
          end else begin
            next_state = ST_FEED;
          end
        end else if (tmr_tc) begin
          err_set    = 1'b1;
          next_state = ST_DONE;
        end
      end
      ST_FEED: begin
        src_ready = !crc_buffer_full && !job_abort;
        if (src_valid && src_ready) begin
          crc_buffer_write_en = 1'b1;
          crc_bus_wr          = src_data;
          rem_dec             = 1'b1;
          if (remaining == LEN_W'(1)) begin
            next_state = ST_DRAIN;
            tmr_clr    = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        tmr_en = 1'b1;
        // Count of zero marks the settle cycle after the last write
        if (tmr_count != TMR_W'(0)) begin
          if (!crc_read_wait) begin
            res_cap    = 1'b1;
            next_state = ST_DONE;
          end else if (tmr_tc) begin
            err_set    = 1'b1;
            next_state = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      ST_ABORT: begin
        crc_reset_chain = 1'b1;
        next_state      = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase

    // Abort overrides everything else, including a write handshake
    if (active && job_abort) begin
      next_state          = ST_ABORT;
      src_ready           = 1'b0;
      crc_bus_wr          = '0;
      crc_poly_en         = 1'b0;
      crc_init_en         = 1'b0;
      crc_reset_chain     = 1'b0;
      crc_buffer_write_en = 1'b0;
      rem_dec             = 1'b0;
      res_cap             = 1'b0;
      err_set             = 1'b1;
    end

    // No strobe may escape during a reset cycle
    if (!rst_n) begin
      src_ready           = 1'b0;
      crc_bus_wr          = '0;
      crc_poly_en         = 1'b0;
      crc_init_en         = 1'b0;
      crc_reset_chain     = 1'b0;
      crc_buffer_write_en = 1'b0;
    end
  end

  // Job registers, word counter and status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_q     <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      result    <= '0;
    end else begin
      busy <= (next_state != ST_IDLE);
      done <= (next_state == ST_DONE) || (next_state == ST_ABORT);
      if (state == ST_IDLE && job_start) begin
        cfg_q <= '{poly:      job_poly,
                   init:      job_init,
                   poly_size: job_poly_size,
                   bus_size:  job_bus_size,
                   rev_in:    job_rev_in,
                   rev_out:   job_rev_out};
        remaining <= job_len;
        err       <= 1'b0;
      end else if (err_set) begin
        err <= 1'b1;
      end
      if (rem_dec) remaining <= remaining - LEN_W'(1);
      if (res_cap) result <= crc_out;
    end
  end

endmodule

// File: tb/tb_crc_job_sequencer.sv
// Self-checking bench for crc_job_sequencer with a behavioural crc_unit
// (MSB-first byte CRC, 2-cycle reset_pending, 1-cycle read_wait after writes).
module tb_crc_job_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_start, job_abort;
  logic [31:0] job_poly, job_init;
  logic [1:0]  job_poly_size, job_bus_size, job_rev_in;
  logic        job_rev_out;
  logic [15:0] job_len;
  logic [31:0] src_data;
  logic        src_valid, src_ready;
  logic        busy, done, err;
  logic [31:0] result, crc_bus_wr, crc_out;
  logic [1:0]  crc_poly_size, crc_bus_size, crc_rev_in;
  logic        crc_rev_out, crc_init_en, crc_poly_en, crc_idr_en;
  logic        crc_buffer_write_en, crc_reset_chain;
  logic        crc_buffer_full, crc_read_wait, crc_reset_pending;

  // crc_unit model state
  logic [31:0] m_poly, m_init, m_crc;
  logic [1:0]  pend_cnt;
  logic        rw_cnt;
  logic        force_full, force_rw;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  msg [9];

  typedef struct {
    logic        err;
    logic        chk;
    logic [31:0] res;
  } exp_t;
  exp_t sb[$];

  crc_job_sequencer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .job_start           (job_start),
    .job_abort           (job_abort),
    .job_poly            (job_poly),
    .job_init            (job_init),
    .job_poly_size       (job_poly_size),
    .job_bus_size        (job_bus_size),
    .job_rev_in          (job_rev_in),
    .job_rev_out         (job_rev_out),
    .job_len             (job_len),
    .src_data            (src_data),
    .src_valid           (src_valid),
    .src_ready           (src_ready),
    .busy                (busy),
    .done                (done),
    .err                 (err),
    .result              (result),
    .crc_bus_wr          (crc_bus_wr),
    .crc_poly_size       (crc_poly_size),
    .crc_bus_size        (crc_bus_size),
    .crc_rev_in          (crc_rev_in),
    .crc_rev_out         (crc_rev_out),
    .crc_init_en         (crc_init_en),
    .crc_poly_en         (crc_poly_en),
    .crc_idr_en          (crc_idr_en),
    .crc_buffer_write_en (crc_buffer_write_en),
    .crc_reset_chain     (crc_reset_chain),
    .crc_out             (crc_out),
    .crc_buffer_full     (crc_buffer_full),
    .crc_read_wait       (crc_read_wait),
    .crc_reset_pending   (crc_reset_pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] crc_step8(input logic [31:0] c, input logic [31:0] p,
                                            input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {b, 24'h0};
    for (int i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ p) : (r << 1);
    return r;
  endfunction

  assign crc_out           = m_crc;
  assign crc_reset_pending = (pend_cnt != 2'd0);
  assign crc_read_wait     = force_rw || rw_cnt;
  assign crc_buffer_full   = force_full;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_poly <= '0; m_init <= '0; m_crc <= '0; pend_cnt <= '0; rw_cnt <= 1'b0;
    end else begin
      if (crc_poly_en) m_poly <= crc_bus_wr;
      if (crc_init_en) m_init <= crc_bus_wr;
      if (crc_reset_chain) begin
        m_crc <= m_init; pend_cnt <= 2'd2;
      end else if (pend_cnt != 2'd0) begin
        pend_cnt <= pend_cnt - 2'd1;
      end
      if (crc_buffer_write_en) begin
        m_crc  <= crc_step8(m_crc, m_poly, crc_bus_wr[7:0]);
        rw_cnt <= 1'b1;
      end else begin
        rw_cnt <= 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // lat_mode: 0 none, 1 start->done == exp_lat, 2 drain entry->done == 256
  task automatic run_job(input logic [31:0] poly, input logic [31:0] init, input int n,
                         input logic [31:0] exp_res, input logic exp_err, input logic chk_res,
                         input int full_at, input int abort_at, input int lat_mode,
                         input int exp_lat);
    int   t0, drain_cyc, idx, fullcnt;
    logic full_used, got, hs;
    exp_t e;
    @(negedge clk);
    job_poly = poly; job_init = init; job_len = 16'(n);
    job_poly_size = 2'b00; job_bus_size = 2'b00; job_rev_in = 2'b00; job_rev_out = 1'b0;
    job_start = 1'b1;
    e.err = exp_err; e.chk = chk_res; e.res = exp_res;
    sb.push_back(e);
    @(negedge clk);
    job_start = 1'b0;
    t0 = cyc;
    check_eq("busy_start", busy, 1);
    check_eq("cfg_poly_en", crc_poly_en, 1);
    check_eq("cfg_poly_bus", crc_bus_wr, poly);
    idx = 0; fullcnt = 0; full_used = 1'b0; got = 1'b0; drain_cyc = 0;
    for (int c = 0; c < 2000 && !got; c++) begin
      if (done) begin
        if (sb.size() == 0) begin
          check_eq("sb_empty", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq("err", err, e.err);
          if (e.chk) check_eq("result", result, e.res);
        end
        if (abort_at >= 0) check_eq("abort_rst_chain", crc_reset_chain, 1);
        else               check_eq("words_fed", idx, n);
        if (lat_mode == 1) check_eq("latency", cyc - t0, exp_lat);
        if (lat_mode == 2) check_eq("drain_timeout", cyc - drain_cyc, 256);
        job_abort = 1'b0; src_valid = 1'b0;
        got = 1'b1;
        @(negedge clk);
        check_eq("done_pulse", done, 0);
        check_eq("busy_clear", busy, 0);
      end else begin
        if (full_at >= 0 && idx == full_at && !full_used) begin
          fullcnt = 5; full_used = 1'b1;
        end
        force_full = (fullcnt > 0);
        src_valid  = (idx < n);
        if (idx < n) src_data = {24'h0, msg[idx]};
        else         src_data = 32'h0;
        job_abort  = (abort_at >= 0 && idx == abort_at);
        #1;
        hs = src_valid && src_ready;
        if (force_full) begin
          check_eq("full_no_ready", src_ready, 0);
          check_eq("full_no_wr", crc_buffer_write_en, 0);
          fullcnt--;
        end
        if (job_abort) check_eq("abort_no_wr", crc_buffer_write_en, 0);
        if (hs) begin
          check_eq("wr_strobe", crc_buffer_write_en, 1);
          check_eq("wr_data", crc_bus_wr, src_data);
        end
        @(negedge clk);
        if (hs && !job_abort) begin
          idx++;
          if (idx == n) drain_cyc = cyc;
        end
      end
    end
    if (!got) check_eq("job_timeout", 0, 1);
    src_valid = 1'b0; job_abort = 1'b0; force_full = 1'b0;
  endtask

  initial begin
    int   idx;
    logic hs;
    for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
    rst_n = 1'b0; job_start = 1'b0; job_abort = 1'b0;
    job_poly = '0; job_init = '0; job_poly_size = '0; job_bus_size = '0;
    job_rev_in = '0; job_rev_out = 1'b0; job_len = '0;
    src_data = '0; src_valid = 1'b0; force_full = 1'b0; force_rw = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_src_ready", src_ready, 0);
    check_eq("rst_bus_wr", crc_bus_wr, 0);
    check_eq("rst_strobes", {crc_init_en, crc_poly_en, crc_idr_en, crc_buffer_write_en,
                             crc_reset_chain}, 0);
    rst_n = 1'b1;

    // CRC-32/MPEG-2 of "123456789"
    run_job(32'h04C11DB7, 32'hFFFFFFFF, 9, 32'h0376E6E7, 1'b0, 1'b1, -1, -1, 0, 0);
    // Back-pressure mid-stream
    run_job(32'h04C11DB7, 32'hFFFFFFFF, 9, 32'h0376E6E7, 1'b0, 1'b1, 4, -1, 0, 0);
    // Empty job: result is the init value, 6 cycles + 2 reset_pending cycles
    run_job(32'h04C11DB7, 32'h12345678, 0, 32'h12345678, 1'b0, 1'b1, -1, -1, 1, 8);
    // Drain timeout
    force_rw = 1'b1;
    run_job(32'h04C11DB7, 32'hFFFFFFFF, 1, 32'h0, 1'b1, 1'b0, -1, -1, 2, 0);
    force_rw = 1'b0;
    // Abort after 3 words: result keeps previous value
    run_job(32'h04C11DB7, 32'hFFFFFFFF, 9, 32'h12345678, 1'b1, 1'b1, -1, 3, 0, 0);
    run_job(32'h04C11DB7, 32'hFFFFFFFF, 9, 32'h0376E6E7, 1'b0, 1'b1, -1, -1, 0, 0);

    // Start while busy is ignored, then reset mid-FEED
    @(negedge clk);
    job_poly = 32'h04C11DB7; job_init = 32'hFFFFFFFF; job_len = 16'd9;
    job_poly_size = 2'b10; job_rev_in = 2'b01; job_rev_out = 1'b1; job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    idx = 0;
    for (int c = 0; c < 100 && idx < 4; c++) begin
      src_valid = 1'b1; src_data = {24'h0, msg[idx]};
      #1;
      hs = src_ready;
      @(negedge clk);
      if (hs) idx++;
    end
    src_valid = 1'b0;
    check_eq("t6_fed", idx, 4);
    job_poly = 32'hDEADBEEF; job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    check_eq("start_ignored_busy", busy, 1);
    check_eq("start_ignored_poly", crc_poly_en, 0);
    check_eq("start_ignored_feed", src_ready, 1);
    src_valid = 1'b1; src_data = {24'h0, msg[4]}; rst_n = 1'b0;
    #1;
    check_eq("rst_cycle_no_wr", crc_buffer_write_en, 0);
    check_eq("rst_cycle_no_ready", src_ready, 0);
    check_eq("rst_cycle_bus", crc_bus_wr, 0);
    @(negedge clk);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_err", err, 0);
    check_eq("midrst_result", result, 0);
    check_eq("midrst_cfg", {crc_poly_size, crc_rev_in, crc_rev_out, crc_bus_size}, 0);
    src_valid = 1'b0; rst_n = 1'b1;

    run_job(32'h04C11DB7, 32'hFFFFFFFF, 9, 32'h0376E6E7, 1'b0, 1'b1, -1, -1, 0, 0);
    check_eq("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
